// File: rtl/sipo_serial_receiver.sv
// Serial-in parallel-out receiver: start-bit detect on an idle-high line, LSB-first
// mid-bit sampling of 8 data bits, stop-bit check, one-cycle valid / error strobes.
module sipo_serial_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       Serial_In,
  output logic [7:0] Parallel_Data,
  output logic       Data_Valid,
  output logic       Framing_Error,
  output logic       Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [2:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_bitCnt;
  logic [7:0]             r_shreg;
  logic [7:0]             r_data;
  logic                   r_valid;
  logic                   r_ferr;
  logic                   r_busy;
  logic                   w_rxS;

  // Synchronizer resets to the idle (high) level so a reset never looks like a start bit.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) r_sync <= '1;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], Serial_In};
  end

  assign w_rxS = r_sync[SYNC_STAGES-1];

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bitCnt <= '0;
      r_shreg  <= 8'hFF;
      r_data   <= 8'h00;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt    <= '0;
          r_bitCnt <= '0;
          if (!w_rxS) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end
        // Re-check the start bit at its midpoint; a high line here means it was a glitch.
        S_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (!w_rxS) begin
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt    <= '0;
            r_shreg  <= {w_rxS, r_shreg[7:1]};
            r_bitCnt <= r_bitCnt + 1'b1;
            if (r_bitCnt == 3'd7) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // Returning to IDLE mid-stop-bit lets a back-to-back start bit be caught on time.
        S_STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt <= '0;
            if (w_rxS) begin
              r_data  <= r_shreg;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (w_rxS) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Parallel_Data = r_data;
  assign Data_Valid    = r_valid;
  assign Framing_Error = r_ferr;
  assign Busy          = r_busy;

endmodule

// File: tb/tb_sipo_serial_receiver.sv
// Randomized frame-level bench for sipo_serial_receiver at CLKS_PER_BIT=16 and 4;
// a queue of predicted strobes (kind, edge, byte) is compared against each pulse.
module tb_sipo_serial_receiver;

  localparam int N0 = 16;
  localparam int N1 = 4;

  typedef struct {
    int         edgeNo;
    bit         isValid;
    logic [7:0] data;
  } evt_t;

  logic       clk;
  logic       reset;
  logic [1:0] serialIn;
  logic [7:0] pd0, pd1;
  logic [1:0] dv, fe, busy;

  int   edgeCount;
  int   checks;
  int   errors;
  evt_t expQ0[$];
  evt_t expQ1[$];
  logic [7:0] lastData[2];
  int   lastValidEdge[2];
  int   prevValidEdge[2];
  bit   prevPulse[2];

  sipo_serial_receiver #(.CLKS_PER_BIT(N0), .SYNC_STAGES(2)) dut0 (
    .CLOCK_50(clk), .Reset(reset), .Serial_In(serialIn[0]),
    .Parallel_Data(pd0), .Data_Valid(dv[0]), .Framing_Error(fe[0]), .Busy(busy[0])
  );

  sipo_serial_receiver #(.CLKS_PER_BIT(N1), .SYNC_STAGES(2)) dut1 (
    .CLOCK_50(clk), .Reset(reset), .Serial_In(serialIn[1]),
    .Parallel_Data(pd1), .Data_Valid(dv[1]), .Framing_Error(fe[1]), .Busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edgeCount = 0;
  always @(posedge clk) edgeCount <= edgeCount + 1;

  function automatic int nOf(int i);
    return (i == 0) ? N0 : N1;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edgeCount);
    end
  endtask

  function automatic int qSize(int i);
    return (i == 0) ? expQ0.size() : expQ1.size();
  endfunction

  // Reference model: a frame's outcome depends only on its stop bit, and its strobe
  // follows the stop-bit sample at t0 + 2 + N/2 + 9N.
  task automatic pushExp(int i, int t0, logic [7:0] data, bit stopBit);
    evt_t ev;
    ev.edgeNo  = t0 + 2 + nOf(i) / 2 + 9 * nOf(i);
    ev.isValid = stopBit;
    ev.data    = data;
    if (i == 0) expQ0.push_back(ev);
    else        expQ1.push_back(ev);
  endtask

  task automatic monitorInst(int i);
    logic       v, e;
    logic [7:0] p;
    evt_t       ev;
    bit         have;
    v = dv[i];
    e = fe[i];
    p = (i == 0) ? pd0 : pd1;
    if (v || e) begin
      checkOutput("exclusive", {31'd0, v & e}, 32'd0);
      checkOutput("singleCycle", {31'd0, prevPulse[i]}, 32'd0);
      have = qSize(i) > 0;
      checkOutput("pulseExpected", {31'd0, have}, 32'd1);
      if (have) begin
        if (i == 0) ev = expQ0.pop_front();
        else        ev = expQ1.pop_front();
        checkOutput("pulseEdge", edgeCount, ev.edgeNo);
        checkOutput("pulseKind", {31'd0, v}, {31'd0, ev.isValid});
        if (ev.isValid) begin
          lastData[i] = ev.data;
          checkOutput("data", {24'd0, p}, {24'd0, ev.data});
          checkOutput("busyAfterValid", {31'd0, busy[i]}, 32'd0);
        end else begin
          checkOutput("dataHeld", {24'd0, p}, {24'd0, lastData[i]});
          checkOutput("busyAfterError", {31'd0, busy[i]}, 32'd1);
        end
      end
      if (v) begin
        prevValidEdge[i] = lastValidEdge[i];
        lastValidEdge[i] = edgeCount;
      end
    end
    prevPulse[i] = v | e;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) monitorInst(i);
  end

  task automatic waitCycles(int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives nBits bits of a frame (start, D0..D7, stop); called at a negedge, returns at one.
  task automatic applyStimulus(int i, logic [7:0] data, bit stopBit, int nBits);
    logic [7:0] d;
    int t0;
    d = data;
    for (int b = 0; b < nBits; b++) begin
      if (b == 0)      serialIn[i] = 1'b0;
      else if (b <= 8) serialIn[i] = d[b-1];
      else             serialIn[i] = stopBit;
      if (b == 0) begin
        t0 = edgeCount + 1;
        if (nBits == 10) pushExp(i, t0, data, stopBit);
      end
      waitCycles(nOf(i));
    end
  endtask

  task automatic drain(int i, string tag);
    waitCycles(3 * nOf(i) + 5);
    checkOutput(tag, qSize(i), 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    serialIn = 2'b11;
    expQ0.delete();
    expQ1.delete();
    lastData[0] = 8'h00;
    lastData[1] = 8'h00;
    waitCycles(3);
    checkOutput("rstData0", {24'd0, pd0}, 32'h00);
    checkOutput("rstData1", {24'd0, pd1}, 32'h00);
    checkOutput("rstValid", {30'd0, dv}, 32'd0);
    checkOutput("rstFerr", {30'd0, fe}, 32'd0);
    checkOutput("rstBusy", {30'd0, busy}, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int busyCount;
    int t0;
    logic [7:0] rb;
    bit stopBit;
    int gap;
    checks = 0;
    errors = 0;
    lastValidEdge = '{0, 0};
    prevValidEdge = '{0, 0};
    prevPulse = '{0, 0};
    reset = 1'b1;
    serialIn = 2'b11;
    @(negedge clk);
    doReset();

    // 0xA5 with the start bit first sampled at edge 100.
    while (edgeCount < 99) @(negedge clk);
    applyStimulus(0, 8'hA5, 1'b1, 10);
    serialIn[0] = 1'b1;
    drain(0, "drainA5");
    checkOutput("a5Edge", lastValidEdge[0], 254);
    checkOutput("a5Data", {24'd0, pd0}, 32'hA5);
    checkOutput("a5BusyIdle", {31'd0, busy[0]}, 32'd0);

    // Three-cycle glitch must not start a frame.
    busyCount = 0;
    serialIn[0] = 1'b0;
    repeat (3) begin @(negedge clk); busyCount += int'(busy[0]); end
    serialIn[0] = 1'b1;
    repeat (N0 + 5) begin @(negedge clk); busyCount += int'(busy[0]); end
    checkOutput("glitchBusyLen", {31'd0, (busyCount >= 1) && (busyCount <= N0 / 2 + 1)}, 32'd1);
    checkOutput("glitchBusyEnd", {31'd0, busy[0]}, 32'd0);
    checkOutput("glitchData", {24'd0, pd0}, 32'hA5);

    // Framing error, then a held-low break, then recovery.
    applyStimulus(0, 8'h3C, 1'b0, 10);
    waitCycles(40);
    checkOutput("breakPulses", qSize(0), 0);
    checkOutput("breakData", {24'd0, pd0}, 32'hA5);
    serialIn[0] = 1'b1;
    waitCycles(N0);
    applyStimulus(0, 8'h11, 1'b1, 10);
    serialIn[0] = 1'b1;
    drain(0, "drain11");
    checkOutput("recoverData", {24'd0, pd0}, 32'h11);

    // Back-to-back frames with no idle bits in between.
    applyStimulus(0, 8'h00, 1'b1, 10);
    applyStimulus(0, 8'hFF, 1'b1, 10);
    serialIn[0] = 1'b1;
    drain(0, "drainB2B");
    checkOutput("b2bSpacing", lastValidEdge[0] - prevValidEdge[0], 10 * N0);
    checkOutput("b2bData", {24'd0, pd0}, 32'hFF);

    // Reset in the middle of D4 of 0x5A.
    applyStimulus(0, 8'h5A, 1'b1, 5);
    serialIn[0] = 1'b1;
    waitCycles(N0 / 2);
    checkOutput("midFrameBusy", {31'd0, busy[0]}, 32'd1);
    doReset();
    waitCycles(N0);
    applyStimulus(0, 8'hC3, 1'b1, 10);
    serialIn[0] = 1'b1;
    drain(0, "drainC3");
    checkOutput("c3Data", {24'd0, pd0}, 32'hC3);

    // 0xA5 on the CLKS_PER_BIT=4 instance.
    t0 = edgeCount + 1;
    applyStimulus(1, 8'hA5, 1'b1, 10);
    serialIn[1] = 1'b1;
    drain(1, "drainN4");
    checkOutput("n4Edge", lastValidEdge[1], t0 + 40);
    checkOutput("n4Data", {24'd0, pd1}, 32'hA5);

    // Random frames with random gaps and occasional bad stop bits on both instances.
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 12; k++) begin
        rb = 8'($urandom);
        stopBit = ($urandom_range(0, 4) != 0);
        applyStimulus(i, rb, stopBit, 10);
        serialIn[i] = 1'b1;
        gap = stopBit ? $urandom_range(0, 2 * nOf(i)) : $urandom_range(nOf(i), 3 * nOf(i));
        waitCycles(gap);
      end
      drain(i, "drainRandom");
      checkOutput("randomBusyEnd", {31'd0, busy[i]}, 32'd0);
      checkOutput("randomLastData", {24'd0, (i == 0) ? pd0 : pd1}, {24'd0, lastData[i]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
